// File: rtl/sequenciador_ula_if.sv
// sequenciador_ula_if: command, response and ULA pin bundle for the ULA sequencer
interface sequenciador_ula_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_dado;
    logic       res_zero;
    logic       res_erro;
    logic [7:0] ula_entrada1;
    logic [7:0] ula_entrada2;
    logic [1:0] ula_op;
    logic [7:0] ula_resultado;
    logic       ula_zero;

    // environment side: issues commands, takes responses, hosts the combinational ULA
    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready, ula_resultado, ula_zero,
        input  cmd_ready, res_valid, res_dado, res_zero, res_erro, ula_entrada1, ula_entrada2, ula_op
    );

    // sequencer side
    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready, ula_resultado, ula_zero,
        output cmd_ready, res_valid, res_dado, res_zero, res_erro, ula_entrada1, ula_entrada2, ula_op
    );
endinterface

// File: rtl/sequenciador_ula.sv
// sequenciador_ula: multi-cycle command sequencer around the 8-bit ULA; define SEQ_ULA_MUL_EN to build the 8-step shift-add MUL
module sequenciador_ula (
    input logic               clock,
    input logic               reset,
    sequenciador_ula_if.slave bus
);
    typedef enum logic [1:0] {OCIOSO, EXEC, MUL_PASSO, RESPOSTA} estado_t;

    estado_t    estado, proximo;
    logic [2:0] op;
    logic [7:0] a, b;
    logic       aceita, ilegal;
`ifdef SEQ_ULA_MUL_EN
    logic [7:0] acc, mcand, mplier;
    logic [2:0] k;
    assign ilegal = bus.cmd_op[2:1] == 2'b11;
`else
    assign ilegal = bus.cmd_op[2] && bus.cmd_op != 3'b101;
`endif

    assign aceita        = bus.cmd_valid && estado == OCIOSO;
    assign bus.cmd_ready = estado == OCIOSO;
    assign bus.res_valid = estado == RESPOSTA;

    // next state and ULA drive; ULA pins depend only on latched registers
    always_comb begin
        proximo          = estado;
        bus.ula_entrada1 = 8'h00;
        bus.ula_entrada2 = 8'h00;
        bus.ula_op       = 2'b00;
        case (estado)
            OCIOSO:   if (aceita) proximo = ilegal ? RESPOSTA : (bus.cmd_op == 3'b100 ? MUL_PASSO : EXEC);
            EXEC: begin
                bus.ula_entrada1 = a;
                bus.ula_entrada2 = (op == 3'b001 || op[2]) ? 8'h00 : b;
                bus.ula_op       = op[2] ? {1'b0, a[7]} : op[1:0];
                proximo          = RESPOSTA;
            end
`ifdef SEQ_ULA_MUL_EN
            MUL_PASSO: begin
                bus.ula_entrada1 = acc;
                bus.ula_entrada2 = mplier[0] ? mcand : 8'h00;
                proximo          = k == 3'd7 ? RESPOSTA : MUL_PASSO;
            end
`endif
            RESPOSTA: if (bus.res_ready) proximo = OCIOSO;
            default:  proximo = OCIOSO;
        endcase
    end

    // state, operand latches and held response registers
    always_ff @(posedge clock) begin
        if (reset) begin
            estado       <= OCIOSO;
            op           <= 3'b000;
            a            <= 8'h00;
            b            <= 8'h00;
            bus.res_dado <= 8'h00;
            bus.res_zero <= 1'b0;
            bus.res_erro <= 1'b0;
`ifdef SEQ_ULA_MUL_EN
            acc          <= 8'h00;
            mcand        <= 8'h00;
            mplier       <= 8'h00;
            k            <= 3'd0;
`endif
        end else begin
            estado <= proximo;
            if (aceita) begin
                op <= bus.cmd_op;
                a  <= bus.cmd_a;
                b  <= bus.cmd_b;
`ifdef SEQ_ULA_MUL_EN
                acc    <= 8'h00;
                mcand  <= bus.cmd_a;
                mplier <= bus.cmd_b;
                k      <= 3'd0;
`endif
                if (ilegal) begin
                    bus.res_dado <= 8'h00;
                    bus.res_zero <= 1'b1;
                    bus.res_erro <= 1'b1;
                end
            end
            if (estado == EXEC) begin
                bus.res_dado <= bus.ula_resultado;
                bus.res_zero <= bus.ula_zero;
                bus.res_erro <= 1'b0;
            end
`ifdef SEQ_ULA_MUL_EN
            if (estado == MUL_PASSO) begin
                acc    <= bus.ula_resultado;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                k      <= k + 3'd1;
                if (k == 3'd7) begin
                    bus.res_dado <= bus.ula_resultado;
                    bus.res_zero <= bus.ula_resultado == 8'h00;
                    bus.res_erro <= 1'b0;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_sequenciador_ula.sv
// tb_sequenciador_ula: randomized scoreboard bench for sequenciador_ula with a behavioural ULA and reference model
module tb_sequenciador_ula;
    typedef struct {
        logic [7:0] dado;
        logic       zero;
        logic       erro;
        int         lat;
        int         t;
    } exp_t;

    logic               clock, reset;
    sequenciador_ula_if bus ();
    exp_t               q[$];
    exp_t               cur;
    int                 n_chk, n_fail;
    int                 rr_mode;
    bit                 seen, consumed;
    logic [7:0]         h_dado;
    logic               h_zero, h_erro;
    logic [7:0]         ula_r, ula_d;

    sequenciador_ula dut (.clock(clock), .reset(reset), .bus(bus));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // combinational ULA: 00 add, 01 negate Entrada1, 10 subtract, 11 sign of difference
    always_comb begin
        ula_d  = bus.ula_entrada1 - bus.ula_entrada2;
        ula_r  = bus.ula_op == 2'b00 ? bus.ula_entrada1 + bus.ula_entrada2 :
                 bus.ula_op == 2'b01 ? 8'h00 - bus.ula_entrada1 :
                 bus.ula_op == 2'b10 ? ula_d : (ula_d[7] ? 8'hFF : 8'h00);
        bus.ula_resultado = ula_r;
        bus.ula_zero      = ula_r == 8'h00;
    end

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    function automatic exp_t modelo(input int op, input int a, input int b);
        exp_t e;
        int   r;
        e.erro = 1'b0;
        e.lat  = 2;
        r      = 0;
        case (op)
            0: r = a + b;
            1: r = -a;
            2: r = a - b;
            3: r = ((a - b) & 128) != 0 ? 255 : 0;
`ifdef SEQ_ULA_MUL_EN
            4: begin r = a * b; e.lat = 9; end
`endif
            5: r = a >= 128 ? 256 - a : a;
            default: begin e.erro = 1'b1; e.lat = 1; end
        endcase
        e.dado = 8'(r & 255);
        e.zero = e.dado == 8'h00;
        e.t    = 0;
        return e;
    endfunction

    task automatic send(input int op, input int a, input int b);
        exp_t e;
        int   w;
        w = 0;
        @(negedge clock);
        while (!bus.cmd_ready && w < 100) begin
            @(negedge clock);
            w++;
        end
        if (!bus.cmd_ready) begin
            chk("cmd_ready_timeout", 0, 1);
            return;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'(op);
        bus.cmd_a     = 8'(a);
        bus.cmd_b     = 8'(b);
        e   = modelo(op, a, b);
        e.t = int'($time / 10);
        q.push_back(e);
        @(negedge clock);
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'($urandom_range(0, 7));
        bus.cmd_a     = 8'($urandom);
        bus.cmd_b     = 8'($urandom);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((q.size() != 0 || !bus.cmd_ready) && w < 300) begin
            @(negedge clock);
            w++;
        end
        chk("drain_pending", q.size(), 0);
    endtask

    // consumer ready: 0 always ready, 1 random, 2 held low
    initial begin
        bus.res_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1 bus.res_ready = rr_mode == 0 ? 1'b1 : rr_mode == 1 ? ($urandom_range(0, 1) == 1) : 1'b0;
        end
    end

    // monitor: pop one expectation per new response, then check it stays stable until taken
    always @(negedge clock) begin
        if (!reset) begin
            if (consumed) begin
                chk("cmd_ready_after_handoff", int'(bus.cmd_ready), 1);
                chk("res_valid_after_handoff", int'(bus.res_valid), 0);
                consumed = 1'b0;
            end
            if (bus.res_valid) begin
                if (!seen) begin
                    if (q.size() == 0) begin
                        chk("unexpected_response", 1, 0);
                    end else begin
                        cur = q.pop_front();
                        chk("res_dado", int'(bus.res_dado), int'(cur.dado));
                        chk("res_zero", int'(bus.res_zero), int'(cur.zero));
                        chk("res_erro", int'(bus.res_erro), int'(cur.erro));
                        chk("latency", int'($time / 10) - cur.t, cur.lat);
                        chk("ula_idle_in_resp", int'({bus.ula_entrada1, bus.ula_entrada2, bus.ula_op}), 0);
                    end
                    h_dado = bus.res_dado;
                    h_zero = bus.res_zero;
                    h_erro = bus.res_erro;
                    seen   = 1'b1;
                end else begin
                    chk("res_stable", int'({bus.res_dado, bus.res_zero, bus.res_erro}), int'({h_dado, h_zero, h_erro}));
                end
                chk("cmd_ready_in_resp", int'(bus.cmd_ready), 0);
                if (bus.res_ready) begin
                    seen     = 1'b0;
                    consumed = 1'b1;
                end
            end
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_cmd_ready"}, int'(bus.cmd_ready), 1);
        chk({tag, "_res_valid"}, int'(bus.res_valid), 0);
        chk({tag, "_ula"}, int'({bus.ula_entrada1, bus.ula_entrada2, bus.ula_op}), 0);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rr_mode = 0;
        seen = 1'b0;
        consumed = 1'b0;
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 3'b000;
        bus.cmd_a = 8'h00;
        bus.cmd_b = 8'h00;
        repeat (3) @(negedge clock);
        check_reset_values("reset");
        chk("reset_res", int'({bus.res_dado, bus.res_zero, bus.res_erro}), 0);
        reset = 1'b0;
        send(0, 8'h05, 8'h03);
        send(2, 8'h07, 8'h07);
        send(3, 8'h02, 8'h05);
        send(3, 8'h05, 8'h02);
        send(1, 8'h01, 8'h00);
        send(5, 8'hFB, 8'h00);
        send(5, 8'h80, 8'h00);
        send(5, 8'h00, 8'h00);
        send(4, 8'h0D, 8'h0B);
        send(4, 8'h20, 8'h10);
        send(7, 8'hAA, 8'h55);
        send(6, 8'h01, 8'h02);
        drain();
        rr_mode = 2;
        send(2, 8'h30, 8'h11);
        repeat (7) @(negedge clock);
        rr_mode = 0;
        drain();
        rr_mode = 2;
        @(negedge clock);
        send(4, 8'h0D, 8'h0B);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        q.delete();
        seen = 1'b0;
        consumed = 1'b0;
        check_reset_values("mid_reset");
        rr_mode = 0;
        send(0, 8'h01, 8'h01);
        drain();
        rr_mode = 1;
        for (int i = 0; i < 40; i++) send($urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255));
        rr_mode = 0;
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
